i2s_frame_controller: RTL and testbench

//  Sequencer for basic_i2s_transmit: generates sck and ws from clk, and feeds data_left/data_right.

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_clk_div.sv | 39 +++
 rtl/i2s_frame_controller.sv | 141 ++++++++++++++
 tb/tb_i2s_frame_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default sizing for the I2S frame controller and its clock divider.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } ctrl_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SCK_DIV    = 4;
  localparam int DEF_SLOT_BITS  = 32;

  // Counter width that stays at least one bit wide when the modulus is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock divider: toggles sck every SCK_DIV clk cycles and strobes sck_fall
// in the cycle whose clock edge drives sck from 1 to 0.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int SCK_DIV = DEF_SCK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic sck,
  output logic sck_fall
);

  localparam int DIV_W = cnt_width(SCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             terminal;

  assign terminal = (div_cnt == DIV_LAST);
  assign sck_fall = !clear && terminal && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (terminal) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_frame_controller.sv
// Frame sequencer for an I2S transmitter: one-entry sample buffer, sck/ws generation,
// frame-aligned data registers and underrun flagging. Build option: UNDERRUN_MUTE_EN.
module i2s_frame_controller
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SCK_DIV    = DEF_SCK_DIV,
  parameter int SLOT_BITS  = DEF_SLOT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  output logic                  sck,
  output logic                  ws,
  output logic [DATA_WIDTH-1:0] data_left,
  output logic [DATA_WIDTH-1:0] data_right,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int BIT_W = cnt_width(SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

  ctrl_state_t           state, state_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_left, buf_right;
  logic                  clear, sck_fall, slot_end, frame_end, push;
  logic                  load, mute, fs_nxt, ur_nxt;

  assign s_ready   = ~buf_full;
  assign push      = s_valid && s_ready;
  assign clear     = (state != RUN);
  assign slot_end  = sck_fall && (bit_cnt == BIT_LAST);
  assign frame_end = slot_end && ws;

  i2s_clk_div #(
    .SCK_DIV(SCK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .sck     (sck),
    .sck_fall(sck_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A frame boundary with enable low ends the stream without loading or flagging.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mute      = 1'b0;
    fs_nxt    = 1'b0;
    ur_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && buf_full) begin
          load      = 1'b1;
          fs_nxt    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (!enable) begin
            state_nxt = DRAIN;
          end else if (buf_full) begin
            load   = 1'b1;
            fs_nxt = 1'b1;
          end else begin
            fs_nxt = 1'b1;
            ur_nxt = 1'b1;
`ifdef UNDERRUN_MUTE_EN
            mute   = 1'b1;
`endif
          end
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      ws      <= 1'b0;
    end else if (clear) begin
      bit_cnt <= '0;
      ws      <= 1'b0;
    end else if (slot_end) begin
      bit_cnt <= '0;
      ws      <= ~ws;
    end else if (sck_fall) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Push and load never coincide: s_ready is low whenever there is something to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full  <= 1'b0;
      buf_left  <= '0;
      buf_right <= '0;
    end else if (push) begin
      buf_full  <= 1'b1;
      buf_left  <= s_left;
      buf_right <= s_right;
    end else if (load) begin
      buf_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_left   <= '0;
      data_right  <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= fs_nxt;
      underrun    <= ur_nxt;
      if (load) begin
        data_left  <= buf_left;
        data_right <= buf_right;
      end else if (mute) begin
        data_left  <= '0;
        data_right <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_controller.sv
// Self-checking bench for i2s_frame_controller: random sample stream against a
// frame-level reference model (cycle position within a frame, sample queue of depth one).
module tb_i2s_frame_controller;

  localparam int DW      = 32;
  localparam int SCK_DIV = 4;
  localparam int SLOTS   = 32;
  localparam int HALF    = 2 * SCK_DIV * SLOTS;
  localparam int FRAME   = 2 * HALF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          sck, ws, frame_start, underrun;
  logic [DW-1:0] data_left, data_right;

  int pass_cnt = 0;
  int check_cnt = 0;

  i2s_frame_controller #(
    .DATA_WIDTH(DW),
    .SCK_DIV   (SCK_DIV),
    .SLOT_BITS (SLOTS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .sck        (sck),
    .ws         (ws),
    .data_left  (data_left),
    .data_right (data_right),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %08h, expected %08h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: running flag plus cycle position within the current frame.
  bit            m_run = 0, m_drain = 0, m_full = 0, m_fs = 0, m_ur = 0, m_acc = 0;
  int            m_k = 0;
  logic [DW-1:0] m_buf_l = '0, m_buf_r = '0, m_cur_l = '0, m_cur_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_drain = 0; m_full = 0; m_fs = 0; m_ur = 0; m_acc = 0; m_k = 0;
      m_buf_l = '0; m_buf_r = '0; m_cur_l = '0; m_cur_r = '0;
    end else begin
      m_fs  = 0;
      m_ur  = 0;
      m_acc = s_valid && !m_full;
      if (m_drain) begin
        m_drain = 0;
      end else if (m_run) begin
        m_k++;
        if (m_k == FRAME) begin
          m_k = 0;
          if (!enable) begin
            m_run = 0;
            m_drain = 1;
          end else begin
            m_fs = 1;
            if (m_full) begin
              m_cur_l = m_buf_l; m_cur_r = m_buf_r; m_full = 0;
            end else begin
              m_ur = 1;
`ifdef UNDERRUN_MUTE_EN
              m_cur_l = '0; m_cur_r = '0;
`endif
            end
          end
        end
      end else if (enable && m_full) begin
        m_cur_l = m_buf_l; m_cur_r = m_buf_r; m_full = 0;
        m_fs = 1; m_run = 1; m_k = 0;
      end
      if (m_acc) begin
        m_buf_l = s_left; m_buf_r = s_right; m_full = 1;
      end
    end
  end

  int ur_seen = 0;
  int fs_seen = 0;

  always @(negedge clk) begin
    int e_sck, e_ws;
    e_sck = m_run ? (m_k / SCK_DIV) % 2 : 0;
    e_ws  = m_run ? (m_k / HALF) % 2 : 0;
    checkOutput("sck", 32'(sck), e_sck);
    checkOutput("ws", 32'(ws), e_ws);
    checkOutput("frame_start", 32'(frame_start), 32'(m_fs));
    checkOutput("underrun", 32'(underrun), 32'(m_ur));
    checkOutput("s_ready", 32'(s_ready), 32'(!m_full));
    checkOutput("data_left", data_left, m_cur_l);
    checkOutput("data_right", data_right, m_cur_r);
    if (underrun) ur_seen++;
    if (frame_start) fs_seen++;
  end

  task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(negedge clk);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic waitFrameStart(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 2 * FRAME && !seen; c++) begin
      @(negedge clk);
      if (frame_start) seen = 1;
    end
    if (!seen) checkOutput(tag, 32'd0, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] last_l, last_r;
    int sent;
    bit got_ur;

    $display("[TB] reset and idle phase");
    #2;
    checkOutput("rst_sck", 32'(sck), 32'd0);
    checkOutput("rst_dl", data_left, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rel_ready", 32'(s_ready), 32'd1);
    repeat (1000) @(negedge clk);

    $display("[TB] first pair");
    applyStimulus(32'hA5A5_0001, 32'h5A5A_0002);
    checkOutput("full_ready", 32'(s_ready), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("first_fs", 32'(frame_start), 32'd1);
    checkOutput("first_dl", data_left, 32'hA5A5_0001);
    checkOutput("first_dr", data_right, 32'h5A5A_0002);

    $display("[TB] streaming 100 random pairs");
    ur_seen = 0;
    sent = 0;
    last_l = '0;
    last_r = '0;
    s_valid = 1'b1;
    s_left  = $urandom;
    s_right = $urandom;
    for (int c = 0; c < 60000 && sent < 100; c++) begin
      @(negedge clk);
      if (m_acc) begin
        last_l = s_left;
        last_r = s_right;
        sent++;
        if (sent < 100) begin
          s_left  = $urandom;
          s_right = $urandom;
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
    checkOutput("stream_sent", sent, 32'd100);
    checkOutput("stream_no_ur", ur_seen, 32'd0);

    got_ur = 0;
    for (int c = 0; c < 3 * FRAME && !got_ur; c++) begin
      @(negedge clk);
      if (underrun) got_ur = 1;
    end
    checkOutput("ur_pulse", 32'(got_ur), 32'd1);
    checkOutput("ur_fs", 32'(frame_start), 32'd1);
`ifdef UNDERRUN_MUTE_EN
    checkOutput("ur_dl", data_left, 32'd0);
    checkOutput("ur_dr", data_right, 32'd0);
`else
    checkOutput("ur_dl", data_left, last_l);
    checkOutput("ur_dr", data_right, last_r);
`endif

    $display("[TB] enable drop mid-frame");
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    waitFrameStart("drop_fs_wait");
    checkOutput("drop_dl", data_left, 32'h1234_5678);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    fs_seen = 0;
    repeat (FRAME + 600) @(negedge clk);
    checkOutput("drop_no_fs", fs_seen, 32'd0);
    checkOutput("drop_sck", 32'(sck), 32'd0);
    checkOutput("drop_ws", 32'(ws), 32'd0);
    checkOutput("drop_dr", data_right, 32'h9ABC_DEF0);

    $display("[TB] reset mid-frame");
    enable = 1'b1;
    applyStimulus(32'h0F0F_F0F0, 32'h3C3C_C3C3);
    waitFrameStart("rst_fs_wait");
    repeat (205) @(negedge clk);
    checkOutput("pre_rst_sck", 32'(sck), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_sck", 32'(sck), 32'd0);
    checkOutput("arst_ws", 32'(ws), 32'd0);
    checkOutput("arst_dl", data_left, 32'd0);
    checkOutput("arst_dr", data_right, 32'd0);
    checkOutput("arst_ready", 32'(s_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rerel_ready", 32'(s_ready), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("rerel_sck", 32'(sck), 32'd0);
    applyStimulus(32'hCAFE_0003, 32'hBEEF_0004);
    @(negedge clk);
    checkOutput("restart_fs", 32'(frame_start), 32'd1);
    checkOutput("restart_dl", data_left, 32'hCAFE_0003);
    repeat (FRAME + 50) @(negedge clk);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
